// File: rtl/draw_sprite_ext_if.sv
// +----------------------------------------------------------------------------+
// | Module : draw_sprite_ext_if                                                |
// | Desc   : VGA timing chain + sprite control + sprite ROM bus bundle.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface draw_sprite_ext_if #(
  parameter int ADDR_WIDTH = 14
);
  // upstream timing and colour
  logic [10:0]           hcount_in;
  logic                  hsync_in;
  logic                  hblnk_in;
  logic [10:0]           vcount_in;
  logic                  vsync_in;
  logic                  vblnk_in;
  logic [11:0]           rgb_in;
  // sprite controls
  logic                  visible;
  logic                  mirror;
  logic [10:0]           xpos;
  logic [10:0]           ypos;
  // sprite ROM
  logic [11:0]           rgb_pixel;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  // downstream timing and colour
  logic [10:0]           hcount_out;
  logic                  hsync_out;
  logic                  hblnk_out;
  logic [10:0]           vcount_out;
  logic                  vsync_out;
  logic                  vblnk_out;
  logic [11:0]           rgb_out;
  logic                  frame_ended_out;

  modport master (
    output hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
    output visible, mirror, xpos, ypos, rgb_pixel,
    input  pixel_addr, hcount_out, hsync_out, hblnk_out, vcount_out,
    input  vsync_out, vblnk_out, rgb_out, frame_ended_out
  );

  modport slave (
    input  hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in,
    input  visible, mirror, xpos, ypos, rgb_pixel,
    output pixel_addr, hcount_out, hsync_out, hblnk_out, vcount_out,
    output vsync_out, vblnk_out, rgb_out, frame_ended_out
  );
endinterface

`default_nettype wire

// File: rtl/draw_sprite_ext.sv
// +----------------------------------------------------------------------------+
// | Module : draw_sprite_ext                                                   |
// | Desc   : Arbitrary-size sprite overlay with colour key, mirroring and      |
// |          per-frame position latch; 2-cycle pipeline to the ROM and back.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module draw_sprite_ext #(
  parameter int          SPR_W      = 128,
  parameter int          SPR_H      = 128,
  parameter int          ADDR_WIDTH = 14,
  parameter int          KEY_EN     = 1,
  parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
  input  logic            pclk,
  input  logic            rst,
  draw_sprite_ext_if.slave bus
);

  localparam logic [11:0]           c_spr_w    = 12'(SPR_W);
  localparam logic [11:0]           c_spr_h    = 12'(SPR_H);
  localparam logic [ADDR_WIDTH-1:0] c_row_step = ADDR_WIDTH'(SPR_W);
  localparam logic [ADDR_WIDTH-1:0] c_col_last = ADDR_WIDTH'(SPR_W - 1);

  // per-frame latched controls
  logic [10:0]           r_xpos_l;
  logic [10:0]           r_ypos_l;
  logic                  r_mirror_l;
  logic [ADDR_WIDTH-1:0] r_row_base;

  // stage 1
  logic [ADDR_WIDTH-1:0] r_pixel_addr;
  logic                  r_in_rect_d1;
  logic [11:0]           r_rgb_d1;
  logic [10:0]           r_hcount_d1;
  logic                  r_hsync_d1;
  logic                  r_hblnk_d1;
  logic [10:0]           r_vcount_d1;
  logic                  r_vsync_d1;
  logic                  r_vblnk_d1;

  // stage 2
  logic [11:0]           r_rgb_d2;
  logic [10:0]           r_hcount_d2;
  logic                  r_hsync_d2;
  logic                  r_hblnk_d2;
  logic [10:0]           r_vcount_d2;
  logic                  r_vsync_d2;
  logic                  r_vblnk_d2;
  logic                  r_frame_ended;

  logic                  w_frame_start;
  logic                  w_line_start;
  logic [10:0]           w_xpos_e;
  logic [10:0]           w_ypos_e;
  logic                  w_mirror_e;
  logic [11:0]           w_h12;
  logic [11:0]           w_v12;
  logic [11:0]           w_x12;
  logic [11:0]           w_y12;
  logic                  w_in_x;
  logic                  w_in_y;
  logic                  w_in_rect;
  logic [ADDR_WIDTH-1:0] w_row_base_nxt;
  logic [ADDR_WIDTH-1:0] w_row_base;
  logic [11:0]           w_col;
  logic [ADDR_WIDTH-1:0] w_col_a;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_key_hit;

  assign w_frame_start = (bus.hcount_in == 11'd0) && (bus.vcount_in == 11'd0);
  assign w_line_start  = (bus.hcount_in == 11'd0);

  // The (0,0) cycle already sees the new frame's controls.
  assign w_xpos_e   = w_frame_start ? bus.xpos   : r_xpos_l;
  assign w_ypos_e   = w_frame_start ? bus.ypos   : r_ypos_l;
  assign w_mirror_e = w_frame_start ? bus.mirror : r_mirror_l;

  assign w_h12 = {1'b0, bus.hcount_in};
  assign w_v12 = {1'b0, bus.vcount_in};
  assign w_x12 = {1'b0, w_xpos_e};
  assign w_y12 = {1'b0, w_ypos_e};

  assign w_in_x    = (w_h12 >= w_x12) && (w_h12 < (w_x12 + c_spr_w));
  assign w_in_y    = (w_v12 >= w_y12) && (w_v12 < (w_y12 + c_spr_h));
  assign w_in_rect = bus.visible && w_in_x && w_in_y;

  // Row base advances once per sprite row regardless of what was drawn,
  // so clipped or hidden pixels never skew later rows.
  always_comb begin
    w_row_base_nxt = r_row_base;
    if (w_v12 == w_y12) begin
      w_row_base_nxt = '0;
    end else if ((w_v12 > w_y12) && (w_v12 < (w_y12 + c_spr_h))) begin
      w_row_base_nxt = r_row_base + c_row_step;
    end
    if (w_frame_start) begin
      w_row_base_nxt = '0;
    end
  end

  // Pixel 0 of a line must already use that line's base.
  assign w_row_base = w_line_start ? w_row_base_nxt : r_row_base;

  assign w_col    = w_h12 - w_x12;
  assign w_col_a  = ADDR_WIDTH'(w_col);
  assign w_offset = w_mirror_e ? (c_col_last - w_col_a) : w_col_a;
  assign w_addr   = w_row_base + w_offset;

  assign w_key_hit = (KEY_EN != 0) && (bus.rgb_pixel == KEY_COLOR);

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_xpos_l      <= '0;
      r_ypos_l      <= '0;
      r_mirror_l    <= 1'b0;
      r_row_base    <= '0;
      r_pixel_addr  <= '0;
      r_in_rect_d1  <= 1'b0;
      r_rgb_d1      <= '0;
      r_hcount_d1   <= '0;
      r_hsync_d1    <= 1'b0;
      r_hblnk_d1    <= 1'b0;
      r_vcount_d1   <= '0;
      r_vsync_d1    <= 1'b0;
      r_vblnk_d1    <= 1'b0;
      r_rgb_d2      <= '0;
      r_hcount_d2   <= '0;
      r_hsync_d2    <= 1'b0;
      r_hblnk_d2    <= 1'b0;
      r_vcount_d2   <= '0;
      r_vsync_d2    <= 1'b0;
      r_vblnk_d2    <= 1'b0;
      r_frame_ended <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_xpos_l   <= bus.xpos;
        r_ypos_l   <= bus.ypos;
        r_mirror_l <= bus.mirror;
      end
      if (w_line_start) begin
        r_row_base <= w_row_base_nxt;
      end

      r_pixel_addr <= w_in_rect ? w_addr : '0;
      r_in_rect_d1 <= w_in_rect;
      r_rgb_d1     <= bus.rgb_in;
      r_hcount_d1  <= bus.hcount_in;
      r_hsync_d1   <= bus.hsync_in;
      r_hblnk_d1   <= bus.hblnk_in;
      r_vcount_d1  <= bus.vcount_in;
      r_vsync_d1   <= bus.vsync_in;
      r_vblnk_d1   <= bus.vblnk_in;

      r_rgb_d2    <= (r_in_rect_d1 && !w_key_hit) ? bus.rgb_pixel : r_rgb_d1;
      r_hcount_d2 <= r_hcount_d1;
      r_hsync_d2  <= r_hsync_d1;
      r_hblnk_d2  <= r_hblnk_d1;
      r_vcount_d2 <= r_vcount_d1;
      r_vsync_d2  <= r_vsync_d1;
      r_vblnk_d2  <= r_vblnk_d1;
      // Rises in the same cycle vsync_out does; r_vsync_d2 is its previous value.
      r_frame_ended <= r_vsync_d1 && !r_vsync_d2;
    end
  end

  assign bus.pixel_addr      = r_pixel_addr;
  assign bus.rgb_out         = r_rgb_d2;
  assign bus.hcount_out      = r_hcount_d2;
  assign bus.hsync_out       = r_hsync_d2;
  assign bus.hblnk_out       = r_hblnk_d2;
  assign bus.vcount_out      = r_vcount_d2;
  assign bus.vsync_out       = r_vsync_d2;
  assign bus.vblnk_out       = r_vblnk_d2;
  assign bus.frame_ended_out = r_frame_ended;

endmodule

`default_nettype wire

// File: tb/tb_draw_sprite_ext.sv
// +----------------------------------------------------------------------------+
// | Module : tb_draw_sprite_ext                                                |
// | Desc   : Directed bench: 100x3 keyed sprite and 128x128 unkeyed sprite.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_draw_sprite_ext;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  draw_sprite_ext_if #(.ADDR_WIDTH(9))  bus_a ();
  draw_sprite_ext_if #(.ADDR_WIDTH(14)) bus_b ();

  draw_sprite_ext #(
    .SPR_W(100), .SPR_H(3), .ADDR_WIDTH(9), .KEY_EN(1), .KEY_COLOR(12'hF0F)
  ) dut_a (
    .pclk(pclk), .rst(rst), .bus(bus_a)
  );

  draw_sprite_ext #(
    .SPR_W(128), .SPR_H(128), .ADDR_WIDTH(14), .KEY_EN(0), .KEY_COLOR(12'hF0F)
  ) dut_b (
    .pclk(pclk), .rst(rst), .bus(bus_b)
  );

  // ROM image: every word 0A0 except the key colour at address 5
  function automatic logic [11:0] rom_word(input int a);
    return (a == 5) ? 12'hF0F : 12'h0A0;
  endfunction

  assign bus_a.rgb_pixel = rom_word(int'(bus_a.pixel_addr));
  assign bus_b.rgb_pixel = rom_word(int'(bus_b.pixel_addr));

  int          tests = 0;
  int          fails = 0;
  logic [10:0] xp;
  logic [10:0] yp;
  logic        mir;
  logic        vis;
  logic        vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [10:0] h, input logic [10:0] v);
    bus_a.hcount_in = h;        bus_b.hcount_in = h;
    bus_a.vcount_in = v;        bus_b.vcount_in = v;
    bus_a.hsync_in  = h[0];     bus_b.hsync_in  = h[0];
    bus_a.hblnk_in  = h[1];     bus_b.hblnk_in  = h[1];
    bus_a.vblnk_in  = v[0];     bus_b.vblnk_in  = v[0];
    bus_a.vsync_in  = vs;       bus_b.vsync_in  = vs;
    bus_a.rgb_in    = {1'b1, h}; bus_b.rgb_in   = {1'b1, h};
    bus_a.visible   = vis;      bus_b.visible   = vis;
    bus_a.mirror    = mir;      bus_b.mirror    = mir;
    bus_a.xpos      = xp;       bus_b.xpos      = xp;
    bus_a.ypos      = yp;       bus_b.ypos      = yp;
    @(posedge pclk);
    #1;
  endtask

  // One pixel, then an idle pixel (h=2000, never in a sprite, never a line start)
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic [13:0] ea, input logic [13:0] eb,
                     input logic [11:0] ra, input logic [11:0] rb);
    step(h, v);
    chk({tag, ".addr_a"}, 32'(bus_a.pixel_addr), 32'(ea));
    chk({tag, ".addr_b"}, 32'(bus_b.pixel_addr), 32'(eb));
    step(11'd2000, v);
    chk({tag, ".rgb_a"}, 32'(bus_a.rgb_out), 32'(ra));
    chk({tag, ".rgb_b"}, 32'(bus_b.rgb_out), 32'(rb));
    chk({tag, ".hv_a"}, {10'd0, bus_a.hcount_out, bus_a.vcount_out}, {10'd0, h, v});
    chk({tag, ".sync_a"}, 32'({bus_a.hsync_out, bus_a.hblnk_out, bus_a.vblnk_out}),
        32'({h[0], h[1], v[0]}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vs = 1'b0; vis = 1'b1; mir = 1'b0; xp = 11'd0; yp = 11'd0;
    step(11'd2000, 11'd0);
    step(11'd2000, 11'd0);
    chk("reset.addr_a", 32'(bus_a.pixel_addr), 32'd0);
    chk("reset.rgb_a",  32'(bus_a.rgb_out), 32'd0);
    chk("reset.hc_a",   32'(bus_a.hcount_out), 32'd0);
    chk("reset.fe_a",   32'(bus_a.frame_ended_out), 32'd0);
    rst = 1'b0;

    // frame 1: sprite at origin, key hit at address 5, width-100 wrap
    pix("f1_0_0",    11'd0,   11'd0, 14'd0,   14'd0,   12'h0A0, 12'h0A0);
    pix("f1_5_0",    11'd5,   11'd0, 14'd5,   14'd5,   12'h805, 12'hF0F);
    pix("f1_0_1",    11'd0,   11'd1, 14'd100, 14'd128, 12'h0A0, 12'h0A0);
    pix("f1_0_2",    11'd0,   11'd2, 14'd200, 14'd256, 12'h0A0, 12'h0A0);
    pix("f1_99_2",   11'd99,  11'd2, 14'd299, 14'd355, 12'h0A0, 12'h0A0);
    pix("f1_100_2",  11'd100, 11'd2, 14'd0,   14'd356, 12'h864, 12'h0A0);
    pix("f1_0_3",    11'd0,   11'd3, 14'd0,   14'd384, 12'h800, 12'h0A0);
    vis = 1'b0;
    pix("f1_hid",    11'd20,  11'd3, 14'd0,   14'd0,   12'h814, 12'h814);
    vis = 1'b1;
    pix("f1_21_3",   11'd21,  11'd3, 14'd0,   14'd405, 12'h815, 12'h0A0);

    // frame 2: mirrored at (10,50), then mid-frame move request
    xp = 11'd10; yp = 11'd50; mir = 1'b1;
    pix("f2_0_0",    11'd0,   11'd0,  14'd0,   14'd0,   12'h800, 12'h800);
    pix("f2_0_50",   11'd0,   11'd50, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f2_10_50",  11'd10,  11'd50, 14'd99,  14'd127, 12'h0A0, 12'h0A0);
    pix("f2_109_50", 11'd109, 11'd50, 14'd0,   14'd28,  12'h0A0, 12'h0A0);
    pix("f2_137_50", 11'd137, 11'd50, 14'd0,   14'd0,   12'h889, 12'h0A0);
    xp = 11'd300; mir = 1'b0;
    pix("f2_0_51",   11'd0,   11'd51, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f2_10_51",  11'd10,  11'd51, 14'd199, 14'd255, 12'h0A0, 12'h0A0);
    pix("f2_300_51", 11'd300, 11'd51, 14'd0,   14'd0,   12'h92C, 12'h92C);

    // frame 3: the move takes effect
    pix("f3_0_0",    11'd0,   11'd0,  14'd0,   14'd0,   12'h800, 12'h800);
    pix("f3_0_50",   11'd0,   11'd50, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f3_300_50", 11'd300, 11'd50, 14'd0,   14'd0,   12'h0A0, 12'h0A0);
    pix("f3_305_50", 11'd305, 11'd50, 14'd5,   14'd5,   12'h931, 12'hF0F);
    pix("f3_10_50",  11'd10,  11'd50, 14'd0,   14'd0,   12'h80A, 12'h80A);

    // frame 4: sprite far right, rows still advance by the sprite width
    xp = 11'd1300; yp = 11'd0;
    pix("f4_0_0",    11'd0,    11'd0, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f4_0_1",    11'd0,    11'd1, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f4_0_2",    11'd0,    11'd2, 14'd0,   14'd0,   12'h800, 12'h800);
    pix("f4_1301_2", 11'd1301, 11'd2, 14'd201, 14'd257, 12'h0A0, 12'h0A0);

    // reset for 3 cycles mid-sprite, vsync held high through it
    rst = 1'b1; vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(11'd1302, 11'd2);
      chk("rst_mid.addr_a", 32'(bus_a.pixel_addr), 32'd0);
      chk("rst_mid.rgb_a",  32'(bus_a.rgb_out), 32'd0);
      chk("rst_mid.hc_a",   32'(bus_a.hcount_out), 32'd0);
      chk("rst_mid.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'd0);
    end
    rst = 1'b0;
    step(11'd2000, 11'd2);
    chk("post_rst.fe_a", 32'(bus_a.frame_ended_out), 32'd0);
    step(11'd2000, 11'd2);
    chk("edge1.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'b11);
    step(11'd2000, 11'd2);
    chk("edge1_end.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'b10);

    // second frame boundary
    vs = 1'b0;
    for (int i = 0; i < 3; i++) step(11'd2000, 11'd5);
    chk("low.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'b00);
    vs = 1'b1;
    step(11'd2000, 11'd5);
    chk("edge2_pre.fe_a", 32'(bus_a.frame_ended_out), 32'd0);
    step(11'd2000, 11'd5);
    chk("edge2.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'b11);
    chk("edge2.vs_fe_b", 32'({bus_b.vsync_out, bus_b.frame_ended_out}), 32'b11);
    step(11'd2000, 11'd5);
    chk("edge2_end.vs_fe_a", 32'({bus_a.vsync_out, bus_a.frame_ended_out}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
